// File: rtl/wb_sram_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : wb_sram_pkg
//  Purpose : Shared types and defaults for the Wishbone-to-async-SRAM
//            responder (state encoding, default widths, access timing and
//            counter-width helper).
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package wb_sram_pkg;

   localparam int ADDR_WIDTH_DEF     = 18;
   localparam int DATA_WIDTH_DEF     = 8;
   localparam int ACCESS_CYCLES_DEF  = 4;
   localparam int TIMEOUT_CYCLES_DEF = 255;

   // Bits needed for a down/up counter spanning 0..n-1 (never less than 1).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_GRANT = 3'd1,
      ST_ACCESS     = 3'd2,
      ST_ACK        = 3'd3,
      ST_DONE       = 3'd4
   } state_e;

endpackage : wb_sram_pkg
`default_nettype wire

// File: rtl/wb_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : wb_sram_responder
//  Purpose : Completes Wishbone-style cycles against an external async SRAM.
//            Latches the cycle, requests an SRAM slot from the arbiter, runs
//            a fixed-length timed read or write once granted, returns read
//            data and pulses ack once per cycle.
//  Ports   : clock_i/reset_i      - clock, async active-high reset
//            wb_*                 - initiator side (addr/data/we/cycle in,
//                                   data/ack out), err_o timeout flag
//            ram_req_o/grant_i    - arbiter handshake
//            ram_*                - SRAM pins (tristate buffer lives in top)
//  Options : WB_SRAM_RESPONDER_TIMEOUT_EN - abandon a grant wait after
//            TIMEOUT_CYCLES clocks with an error ack (data all ones).
//  Revision: 1.0  initial release
// ============================================================================
module wb_sram_responder
   import wb_sram_pkg::*;
#(
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int ACCESS_CYCLES  = ACCESS_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cycle_i,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic                  wb_ack_o,
   output logic                  err_o,
   output logic                  ram_req_o,
   input  logic                  ram_grant_i,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   output logic                  ram_data_oe_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic                  ram_we_no,
   output logic                  ram_oe_no
);

   localparam int               CNT_W    = cnt_width(ACCESS_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    we_q, we_d;
   logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
   logic                    drop_q, drop_d;     // initiator abandoned the cycle mid-access
   logic                    req_q, req_d;
   logic                    ack_q, ack_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    ram_we_n_q, ram_we_n_d;
   logic                    ram_oe_n_q, ram_oe_n_d;
   logic                    data_oe_q, data_oe_d;

`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
   localparam int               TMO_W    = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      acc_cnt_d  = acc_cnt_q;
      drop_d     = drop_q;
      req_d      = req_q;
      ack_d      = 1'b0;
      rdata_d    = rdata_q;
      ram_we_n_d = ram_we_n_q;
      ram_oe_n_d = ram_oe_n_q;
      data_oe_d  = data_oe_q;
`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
      tmo_cnt_d  = tmo_cnt_q;
      err_d      = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (wb_cycle_i) begin
               addr_d  = wb_addr_i;
               wdata_d = wb_data_i;
               we_d    = wb_we_i;
               req_d   = 1'b1;
               state_d = ST_WAIT_GRANT;
`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end

         ST_WAIT_GRANT: begin
            // Grant beats a simultaneous cycle drop: the slot is already
            // committed, so the access runs but will not be acknowledged.
            if (ram_grant_i) begin
               state_d   = ST_ACCESS;
               req_d     = 1'b0;
               acc_cnt_d = CNT_LOAD;
               drop_d    = ~wb_cycle_i;
               if (we_q) begin
                  ram_we_n_d = 1'b0;
                  data_oe_d  = 1'b1;
               end else begin
                  ram_oe_n_d = 1'b0;
               end
            end else if (!wb_cycle_i) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = ST_ACK;
               req_d   = 1'b0;
               ack_d   = 1'b1;
               err_d   = 1'b1;
               rdata_d = '1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_ONE;
`endif
            end
         end

         ST_ACCESS: begin
            if (!wb_cycle_i) begin
               drop_d = 1'b1;
            end
            if (acc_cnt_q == '0) begin
               // Final access clock: release the bus and capture read data.
               ram_we_n_d = 1'b1;
               ram_oe_n_d = 1'b1;
               data_oe_d  = 1'b0;
               if (!we_q) begin
                  rdata_d = ram_data_i;
               end
               if (drop_q || !wb_cycle_i) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
               end
            end else begin
               acc_cnt_d = acc_cnt_q - CNT_ONE;
               // we_n rises one clock before the data is released (hold time).
               if (acc_cnt_q == CNT_ONE) begin
                  ram_we_n_d = 1'b1;
               end
            end
         end

         ST_ACK: begin
            state_d = ST_DONE;
         end

         ST_DONE: begin
            // Holding off here until the initiator drops the cycle keeps a
            // still-asserted cycle from being serviced a second time.
            if (!wb_cycle_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         acc_cnt_q  <= '0;
         drop_q     <= 1'b0;
         req_q      <= 1'b0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         ram_we_n_q <= 1'b1;
         ram_oe_n_q <= 1'b1;
         data_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         acc_cnt_q  <= acc_cnt_d;
         drop_q     <= drop_d;
         req_q      <= req_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         ram_we_n_q <= ram_we_n_d;
         ram_oe_n_q <= ram_oe_n_d;
         data_oe_q  <= data_oe_d;
      end
   end

`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign err_o          = 1'b0;
`endif

   assign wb_data_o     = rdata_q;
   assign wb_ack_o      = ack_q;
   assign ram_req_o     = req_q;
   assign ram_addr_o    = addr_q;
   assign ram_data_o    = wdata_q;
   assign ram_data_oe_o = data_oe_q;
   assign ram_we_no     = ram_we_n_q;
   assign ram_oe_no     = ram_oe_n_q;

endmodule : wb_sram_responder
`default_nettype wire

// File: tb/tb_wb_sram_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_wb_sram_responder
//  Purpose : Directed self-checking bench for wb_sram_responder. Stimulus
//            tasks schedule the expected pin timeline per clock from the
//            transaction rules (grant clock g -> access g+1..g+ACC, ack at
//            g+ACC+1); one compare process checks every clock. A byte-array
//            SRAM model answers reads and records writes.
//  Options : WB_SRAM_RESPONDER_TIMEOUT_EN - selects timeout expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_wb_sram_responder;

   localparam int AW  = 18;
   localparam int DW  = 8;
   localparam int ACC = 4;
   localparam int TMO = 8;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b1;
   logic [AW-1:0] wb_addr_i = '0;
   logic [DW-1:0] wb_data_i = '0;
   logic          wb_we_i = 1'b0;
   logic          wb_cycle_i = 1'b0;
   logic [DW-1:0] wb_data_o;
   logic          wb_ack_o;
   logic          err_o;
   logic          ram_req_o;
   logic          ram_grant_i = 1'b0;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_data_o;
   logic          ram_data_oe_o;
   logic [DW-1:0] ram_data_i;
   logic          ram_we_no;
   logic          ram_oe_no;

   wb_sram_responder #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .ACCESS_CYCLES  (ACC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .wb_addr_i     (wb_addr_i),
      .wb_data_i     (wb_data_i),
      .wb_we_i       (wb_we_i),
      .wb_cycle_i    (wb_cycle_i),
      .wb_data_o     (wb_data_o),
      .wb_ack_o      (wb_ack_o),
      .err_o         (err_o),
      .ram_req_o     (ram_req_o),
      .ram_grant_i   (ram_grant_i),
      .ram_addr_o    (ram_addr_o),
      .ram_data_o    (ram_data_o),
      .ram_data_oe_o (ram_data_oe_o),
      .ram_data_i    (ram_data_i),
      .ram_we_no     (ram_we_no),
      .ram_oe_no     (ram_oe_no)
   );

   always #5 clock_i = ~clock_i;

   // ---------------- SRAM model ----------------
   logic [DW-1:0] sram [0:(1<<AW)-1];
   assign ram_data_i = (!ram_oe_no) ? sram[ram_addr_o] : 8'h5A;
   always @(posedge ram_we_no) begin
      if (ram_data_oe_o) sram[ram_addr_o] <= ram_data_o;
   end

   // ---------------- bookkeeping ----------------
   int cyc = 0;
   always @(posedge clock_i) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int ack_seen = 0;
   bit chk_en = 1'b0;

   bit            exp_req  [int];
   bit            exp_we   [int];   // we_no expected low
   bit            exp_oe   [int];   // oe_no expected low
   bit            exp_wdoe [int];
   bit            exp_ack  [int];
   bit            exp_err  [int];
   logic [AW-1:0] exp_addr [int];
   logic [DW-1:0] exp_wdat [int];
   logic [DW-1:0] exp_rd   [int];
   logic [DW-1:0] ref_mem  [int];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
      end
   endtask

   // ---------------- per-clock compare ----------------
   always @(negedge clock_i) begin
      if (wb_ack_o) ack_seen++;
      if (chk_en) begin
         chk("req",     32'(ram_req_o),     32'(exp_req.exists(cyc)));
         chk("we_n",    32'(ram_we_no),     32'(!exp_we.exists(cyc)));
         chk("oe_n",    32'(ram_oe_no),     32'(!exp_oe.exists(cyc)));
         chk("data_oe", 32'(ram_data_oe_o), 32'(exp_wdoe.exists(cyc)));
         chk("ack",     32'(wb_ack_o),      32'(exp_ack.exists(cyc)));
         chk("err",     32'(err_o),         32'(exp_err.exists(cyc)));
         if (exp_addr.exists(cyc)) chk("ram_addr", 32'(ram_addr_o), 32'(exp_addr[cyc]));
         if (exp_wdat.exists(cyc)) chk("ram_wdata", 32'(ram_data_o), 32'(exp_wdat[cyc]));
         if (exp_rd.exists(cyc))   chk("wb_rdata", 32'(wb_data_o), 32'(exp_rd[cyc]));
      end
   end

   // Advance to cycle n, landing 1 time unit after its opening edge.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clock_i);
         #1;
      end
   endtask

   task automatic sched_access(input int g, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit we);
      for (int k = g + 1; k <= g + ACC; k++) begin
         exp_addr[k] = a;
         if (we) begin
            exp_wdoe[k] = 1'b1;
            exp_wdat[k] = d;
            if (k < g + ACC) exp_we[k] = 1'b1;
         end else begin
            exp_oe[k] = 1'b1;
         end
      end
   endtask

   // Full cycle: raise, grant gdly clocks later, hold cycle 'extra' clocks
   // past the ack; optional stray grant while the responder sits in DONE.
   task automatic txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we,
                      input int gdly, input int extra, input bit stray);
      int c, g, ak;
      goto(cyc + 1);
      c = cyc;
      wb_addr_i = a; wb_data_i = d; wb_we_i = we; wb_cycle_i = 1'b1;
      g  = c + gdly;
      ak = g + ACC + 1;
      for (int k = c + 1; k <= g; k++) exp_req[k] = 1'b1;
      sched_access(g, a, d, we);
      if (we) ref_mem[int'(a)] = d;
      else    exp_rd[ak] = ref_mem[int'(a)];
      exp_ack[ak] = 1'b1;
      goto(c + 1);
      wb_addr_i = ~a; wb_data_i = ~d;     // must not leak into the access
      goto(g);
      ram_grant_i = 1'b1;
      goto(g + 1);
      ram_grant_i = 1'b0;
      if (stray) begin
         goto(ak + 1);
         ram_grant_i = 1'b1;
         goto(ak + 2);
         ram_grant_i = 1'b0;
      end
      goto(ak + 1 + extra);
      wb_cycle_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) sram[i] = 8'h00;
      #12;
      // reset values, checked while reset is held
      chk("rst_we_n",    32'(ram_we_no), 32'd1);
      chk("rst_oe_n",    32'(ram_oe_no), 32'd1);
      chk("rst_data_oe", 32'(ram_data_oe_o), 32'd0);
      chk("rst_req",     32'(ram_req_o), 32'd0);
      chk("rst_ack",     32'(wb_ack_o), 32'd0);
      chk("rst_err",     32'(err_o), 32'd0);
      chk("rst_rdata",   32'(wb_data_o), 32'd0);
      chk("rst_addr",    32'(ram_addr_o), 32'd0);
      chk("rst_wdata",   32'(ram_data_o), 32'd0);
      @(posedge clock_i); #1;
      reset_i = 1'b0;
      chk_en  = 1'b1;

      // write A5, grant 3 clocks after request
      txn(18'h12345, 8'hA5, 1'b1, 3, 0, 1'b0);
      goto(cyc + 1);
      chk("sram_12345", 32'(sram[18'h12345]), 32'hA5);
      // read back, cycle held 3 clocks past ack, stray grant in DONE
      txn(18'h12345, 8'h00, 1'b0, 2, 3, 1'b1);
      chk("rd_hold_A5", 32'(wb_data_o), 32'hA5);

      // stray grant in IDLE
      goto(cyc + 1); ram_grant_i = 1'b1;
      goto(cyc + 1); ram_grant_i = 1'b0;

      // abort in WAIT_GRANT, then a late grant
      begin
         int c;
         goto(cyc + 1); c = cyc;
         wb_addr_i = 18'h00BAD; wb_we_i = 1'b1; wb_data_i = 8'hEE; wb_cycle_i = 1'b1;
         exp_req[c + 1] = 1'b1; exp_req[c + 2] = 1'b1;
         goto(c + 2); wb_cycle_i = 1'b0;
         goto(c + 4); ram_grant_i = 1'b1;
         goto(c + 5); ram_grant_i = 1'b0;
         goto(c + 6);
      end

      // cycle drops on the 2nd ACCESS clock of a write: write completes, no ack
      begin
         int c, g;
         goto(cyc + 1); c = cyc; g = c + 2;
         wb_addr_i = 18'h00042; wb_data_i = 8'h3C; wb_we_i = 1'b1; wb_cycle_i = 1'b1;
         for (int k = c + 1; k <= g; k++) exp_req[k] = 1'b1;
         sched_access(g, 18'h00042, 8'h3C, 1'b1);
         ref_mem[32'h42] = 8'h3C;
         goto(g); ram_grant_i = 1'b1;
         goto(g + 1); ram_grant_i = 1'b0;
         goto(g + 2); wb_cycle_i = 1'b0;
         goto(g + ACC + 2);
         chk("sram_42", 32'(sram[18'h00042]), 32'h3C);
      end

      // back-to-back cycles, one idle clock apart
      txn(18'h3FFFF, 8'h5A, 1'b1, 1, 0, 1'b0);
      txn(18'h3FFFF, 8'h00, 1'b0, 1, 0, 1'b0);
      txn(18'h00042, 8'h00, 1'b0, 2, 0, 1'b0);

      // async reset on the 2nd ACCESS clock of a write
      begin
         int c;
         goto(cyc + 1); c = cyc;
         wb_addr_i = 18'h00777; wb_data_i = 8'hC3; wb_we_i = 1'b1; wb_cycle_i = 1'b1;
         exp_req[c + 1] = 1'b1;
         exp_we[c + 2] = 1'b1; exp_wdoe[c + 2] = 1'b1;
         exp_addr[c + 2] = 18'h00777; exp_wdat[c + 2] = 8'hC3;
         goto(c + 1); ram_grant_i = 1'b1;
         goto(c + 2); ram_grant_i = 1'b0;
         goto(c + 3);
         chk_en = 1'b0;
         chk("pre_rst_we_n", 32'(ram_we_no), 32'd0);
         #2 reset_i = 1'b1;
         #1;
         chk("arst_we_n",    32'(ram_we_no), 32'd1);
         chk("arst_oe_n",    32'(ram_oe_no), 32'd1);
         chk("arst_data_oe", 32'(ram_data_oe_o), 32'd0);
         chk("arst_addr",    32'(ram_addr_o), 32'd0);
         wb_cycle_i = 1'b0;
         goto(c + 5);
         reset_i = 1'b0;
         goto(c + 6);
         chk_en = 1'b1;
      end

      txn(18'h00001, 8'h81, 1'b1, 2, 0, 1'b0);
      txn(18'h00001, 8'h00, 1'b0, 1, 0, 1'b0);
      chk("rd_81", 32'(wb_data_o), 32'h81);

      // grant never arrives
      begin
         int c;
         goto(cyc + 1); c = cyc;
         wb_addr_i = 18'h00ABC; wb_we_i = 1'b0; wb_cycle_i = 1'b1;
`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
         for (int k = c + 1; k <= c + TMO; k++) exp_req[k] = 1'b1;
         exp_ack[c + TMO + 1] = 1'b1;
         exp_err[c + TMO + 1] = 1'b1;
         exp_rd[c + TMO + 1]  = 8'hFF;
         goto(c + TMO + 2);
         wb_cycle_i = 1'b0;
         goto(c + TMO + 4);
         chk("tmo_rdata", 32'(wb_data_o), 32'hFF);
`else
         for (int k = c + 1; k <= c + 1100; k++) exp_req[k] = 1'b1;
         goto(c + 1050);
         chk("wait_req", 32'(ram_req_o), 32'd1);
         goto(c + 1100);
         wb_cycle_i = 1'b0;
         goto(c + 1102);
`endif
      end

`ifdef WB_SRAM_RESPONDER_TIMEOUT_EN
      chk("ack_count", 32'(ack_seen), 32'd8);
`else
      chk("ack_count", 32'(ack_seen), 32'd7);
`endif
      @(negedge clock_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wb_sram_responder
`default_nettype wire
